// File: rtl/pac_input_ctrl_if.sv
// rtl/pac_input_ctrl_if.sv - keypad, heading and mouth signals of the Pac-Man input stage
interface pac_input_ctrl_if;
    logic       en;
    logic [3:0] keypad_col;
    logic [3:0] keypad_row;
    logic [1:0] dir;
    logic       dir_changed;
    logic       mouth_closed;

    modport master (
        output en,
        output keypad_col,
        input  keypad_row,
        input  dir,
        input  dir_changed,
        input  mouth_closed
    );

    modport slave (
        input  en,
        input  keypad_col,
        output keypad_row,
        output dir,
        output dir_changed,
        output mouth_closed
    );
endinterface

// File: rtl/pac_input_ctrl.sv
// rtl/pac_input_ctrl.sv - 4x4 keypad scanner, direction debounce and mouth animation toggle
module pac_input_ctrl #(
    parameter int SCAN_DIV  = 2500,
    parameter int DEB_SCANS = 4,
    parameter int MOUTH_DIV = 5000000
) (
    input  logic             clk,
    input  logic             rst_n,
    pac_input_ctrl_if.slave  bus
);
    localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)      : 1;
    localparam int SW = $clog2(DEB_SCANS + 1);
    localparam int MW = (MOUTH_DIV > 1) ? $clog2(MOUTH_DIV)     : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEB_SCANS);
    localparam logic [MW-1:0] MOUTH_LAST = MW'(MOUTH_DIV - 1);

    logic [1:0]    row_idx;
    logic [DW-1:0] dwell_cnt;
    logic [15:0]   snapshot;
    logic          frame_done;
    logic [2:0]    prev_cand;
    logic [SW-1:0] stable_cnt;
    logic [MW-1:0] mouth_cnt;

    logic          cand_valid;
    logic [1:0]    cand_code;
    logic [2:0]    cand;
    logic [SW-1:0] next_stable;
    logic [1:0]    next_row;

    assign next_row = row_idx + 2'd1;

    // Candidate packs {valid, code}; "none" is always 3'b000 so releases compare equal.
    always_comb begin
        cand_valid = 1'b1;
        cand_code  = 2'd0;
        unique case ({snapshot[1], snapshot[9], snapshot[4], snapshot[6]})
            4'b1000: cand_code = 2'd0;
            4'b0100: cand_code = 2'd1;
            4'b0010: cand_code = 2'd2;
            4'b0001: cand_code = 2'd3;
            default: cand_valid = 1'b0;
        endcase
        cand = cand_valid ? {1'b1, cand_code} : 3'b000;
        if (cand != prev_cand)
            next_stable = SW'(1);
        else if (stable_cnt == STABLE_MAX)
            next_stable = STABLE_MAX;
        else
            next_stable = stable_cnt + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx        <= 2'd0;
            dwell_cnt      <= '0;
            snapshot       <= '0;
            frame_done     <= 1'b0;
            bus.keypad_row <= 4'b1110;
        end else begin
            frame_done <= 1'b0;
            if (dwell_cnt == DWELL_LAST) begin
                // Sampling at the end of the dwell lets the column lines settle.
                snapshot[{row_idx, 2'b00} +: 4] <= ~bus.keypad_col;
                frame_done     <= (row_idx == 2'd3);
                dwell_cnt      <= '0;
                row_idx        <= next_row;
                bus.keypad_row <= ~(4'b0001 << next_row);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cand       <= 3'b000;
            stable_cnt      <= '0;
            bus.dir         <= 2'd3;
            bus.dir_changed <= 1'b0;
        end else begin
            bus.dir_changed <= 1'b0;
            if (frame_done) begin
                prev_cand  <= cand;
                stable_cnt <= next_stable;
                if (next_stable == STABLE_MAX && cand_valid && cand_code != bus.dir) begin
                    bus.dir         <= cand_code;
                    bus.dir_changed <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouth_cnt        <= '0;
            bus.mouth_closed <= 1'b0;
        end else if (!bus.en) begin
            mouth_cnt        <= '0;
            bus.mouth_closed <= 1'b0;
        end else if (mouth_cnt == MOUTH_LAST) begin
            mouth_cnt        <= '0;
            bus.mouth_closed <= ~bus.mouth_closed;
        end else begin
            mouth_cnt <= mouth_cnt + MW'(1);
        end
    end
endmodule

// File: tb/tb_pac_input_ctrl.sv
// tb/tb_pac_input_ctrl.sv - scoreboard bench for pac_input_ctrl with a frame-level keypad model
module tb_pac_input_ctrl;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int MD = 10;
    localparam int FRAME = 4 * SD;

    localparam logic [15:0] K_UP    = 16'h0002;
    localparam logic [15:0] K_LEFT  = 16'h0010;
    localparam logic [15:0] K_5     = 16'h0020;
    localparam logic [15:0] K_RIGHT = 16'h0040;
    localparam logic [15:0] K_DOWN  = 16'h0200;
    localparam logic [15:0] DIR_MASK = 16'h0252;

    typedef struct {
        int         cyc;
        logic [1:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] pressed = 16'h0000;
    int cyc = 0;
    int run = 0;
    int checks = 0;
    int passed = 0;
    int fidx = 0;
    ev_t q[$];

    int m_prev;
    int m_cnt;
    int m_dir;
    logic [1:0] exp_last = 2'd3;

    pac_input_ctrl_if bus ();

    pac_input_ctrl #(.SCAN_DIV(SD), .DEB_SCANS(DB), .MOUTH_DIV(MD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Physical keypad: a driven row pulls the columns of its pressed keys low.
    always_comb begin
        logic [3:0] cv;
        cv = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!bus.keypad_row[r]) cv = ~pressed[4*r +: 4];
        bus.keypad_col = cv;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            run <= 0;
        end else begin
            cyc <= cyc + 1;
            run <= bus.en ? run + 1 : 0;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_cyc(input int target);
        if (cyc == target) return;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cyc == target) return;
        end
        check("wait_timeout", cyc, target);
    endtask

    // Frame-level reference: one candidate per frame, accepted after DB identical frames.
    task automatic model_reset();
        m_prev = -1;
        m_cnt  = 0;
        m_dir  = 3;
    endtask

    task automatic model_frame(input logic [15:0] keys, input int f);
        int n;
        int code;
        int c;
        n = 0;
        code = 0;
        if (keys[1]) begin n++; code = 0; end
        if (keys[9]) begin n++; code = 1; end
        if (keys[4]) begin n++; code = 2; end
        if (keys[6]) begin n++; code = 3; end
        c = (n == 1) ? code : -1;
        m_cnt  = (c == m_prev) ? ((m_cnt + 1 > DB) ? DB : m_cnt + 1) : 1;
        m_prev = c;
        if (m_cnt == DB && c >= 0 && c != m_dir) begin
            m_dir = c;
            q.push_back('{cyc: FRAME * (f + 1) + 1, d: 2'(c)});
        end
    endtask

    task automatic frames(input logic [15:0] keys, input int n);
        for (int i = 0; i < n; i++) begin
            wait_cyc(FRAME * fidx);
            pressed = keys;
            model_frame(keys, fidx);
            fidx++;
        end
    endtask

    // Monitor: row drive, mouth level and heading pulses against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_last <= 2'd3;
        end else begin
            check("keypad_row", int'(bus.keypad_row), int'(~(4'b0001 << ((cyc / SD) % 4)) & 4'hF));
            check("mouth_closed", int'(bus.mouth_closed), (run / MD) % 2);
            if (q.size() != 0 && q[0].cyc < cyc) begin
                check("missed_pulse_cycle", cyc, q[0].cyc);
                exp_last <= q[0].d;
                void'(q.pop_front());
            end else if (bus.dir_changed) begin
                if (q.size() == 0) begin
                    check("spurious_dir_changed", 1, 0);
                end else begin
                    check("pulse_cycle", cyc, q[0].cyc);
                    check("pulse_dir", int'(bus.dir), int'(q[0].d));
                    exp_last <= q[0].d;
                    void'(q.pop_front());
                end
            end else begin
                check("dir_hold", int'(bus.dir), int'(exp_last));
            end
        end
    end

    initial begin
        bus.en = 1'b1;
        @(posedge rst_n);
        repeat (15) @(negedge clk);
        bus.en = 1'b0;
        repeat (25) @(negedge clk);
        bus.en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                bus.en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                bus.en = 1'b1;
            end
        end
    end

    initial begin
        logic [15:0] keys;
        int sel;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fidx = 0;

        frames(16'h0000, 2);
        frames(K_LEFT | K_RIGHT, 5);
        frames(16'h0000, 1);
        frames(K_RIGHT | K_5, 3);
        frames(K_LEFT, 2);
        frames(16'h0000, 1);
        frames(K_UP, 4);
        frames(K_DOWN, 3);
        frames(16'h0000, 2);
        frames(K_LEFT, 3);

        for (int i = 0; i < 20; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: keys = 16'h0000;
                1: keys = K_UP;
                2: keys = K_DOWN;
                3: keys = K_LEFT;
                4: keys = K_RIGHT;
                default: keys = 16'($urandom);
            endcase
            if (sel != 5 && $urandom_range(0, 1) == 1)
                keys = keys | (16'($urandom) & 16'($urandom) & ~DIR_MASK);
            frames(keys, $urandom_range(1, 4));
        end
        frames(16'h0000, 2);
        wait_cyc(FRAME * fidx + 4);
        check("queue_drained", q.size(), 0);
        check("final_dir", int'(bus.dir), m_dir);

        pressed = K_UP;
        wait_cyc(cyc + 7);
        rst_n = 1'b0;
        #1;
        check("rst_keypad_row", int'(bus.keypad_row), 4'hE);
        check("rst_dir", int'(bus.dir), 3);
        check("rst_dir_changed", int'(bus.dir_changed), 0);
        check("rst_mouth", int'(bus.mouth_closed), 0);
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fidx = 0;
        frames(K_DOWN, 3);
        frames(16'h0000, 1);
        wait_cyc(FRAME * fidx + 4);
        check("post_reset_queue", q.size(), 0);
        check("post_reset_dir", int'(bus.dir), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
